// File: rtl/shear_stream_mapper.sv
// Shear-stage stream mapper: clears the output frame, then turns raster input
// pixels into frame-buffer writes at their sheared addresses.
module shear_stream_mapper #(
  parameter int ROWS       = 242,
  parameter int COLS       = 247,
  parameter int SHEAR_X_Q8 = 77,
  parameter int SHEAR_Y_Q8 = 102,
  parameter int ADDR_W     = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [7:0]        s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ADDR_W-1:0] m_addr,
  output logic [7:0]        m_data,
  output logic [2:0]        fsm_state
);

  // Handshake: a transfer happens on a rising clk edge where valid && ready;
  // valid never waits on ready, and m_* hold steady while m_valid && !m_ready.

  localparam int OUT_ROWS = ROWS + ((COLS * SHEAR_Y_Q8) >> 8);
  localparam int OUT_COLS = COLS + ((ROWS * SHEAR_X_Q8) >> 8);
  localparam int TOTAL    = OUT_ROWS * OUT_COLS;
  localparam int RW       = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW       = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    MAP   = 3'd2,
    DRAIN = 3'd3,
    FIN   = 3'd4
  } state_t;

  state_t state, next_state;

  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [31:0]   si, sj;
  logic          in_range, last_px, s_fire, m_fire;

  assign fsm_state = state;
  assign s_fire    = s_valid && s_ready;
  assign m_fire    = m_valid && m_ready;
  assign last_px   = (row == RW'(ROWS - 1)) && (col == CW'(COLS - 1));

  always_comb begin
    si       = 32'(row) + ((32'(col) * 32'(SHEAR_Y_Q8)) >> 8);
    sj       = 32'(col) + ((32'(row) * 32'(SHEAR_X_Q8)) >> 8);
    in_range = (si < 32'(OUT_ROWS)) && (sj < 32'(OUT_COLS));
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = CLEAR;
      CLEAR:   if (m_fire && m_addr == LAST_ADDR) next_state = MAP;
      MAP:     if (s_fire && last_px) next_state = DRAIN;
      DRAIN:   if (!m_valid || m_ready) next_state = FIN;
      FIN:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    s_ready = 1'b0;
    case (state)
      CLEAR:   busy = 1'b1;
      MAP: begin
        busy    = 1'b1;
        s_ready = !m_valid || m_ready;
      end
      DRAIN:   busy = 1'b1;
      FIN:     done = 1'b1;
      default: ;
    endcase
  end

  // The clear phase reuses m_addr as its address counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_addr  <= '0;
      m_data  <= '0;
      row     <= '0;
      col     <= '0;
    end else begin
      if (m_fire) m_valid <= 1'b0;
      case (state)
        IDLE: if (start) begin
          m_valid <= 1'b1;
          m_addr  <= '0;
          m_data  <= '0;
          row     <= '0;
          col     <= '0;
        end
        CLEAR: if (m_fire && m_addr != LAST_ADDR) begin
          m_valid <= 1'b1;
          m_addr  <= m_addr + 1'b1;
        end
        MAP: if (s_fire) begin
          if (in_range) begin
            m_valid <= 1'b1;
            m_addr  <= ADDR_W'(si * 32'(OUT_COLS) + sj);
            m_data  <= s_data;
          end
          if (col == CW'(COLS - 1)) begin
            col <= '0;
            row <= row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shear_stream_mapper.sv
// Randomized bench for shear_stream_mapper on a 4x5 image: a reference
// frame model feeds an expected-transaction queue checked against m_* writes.
module tb_shear_stream_mapper;

  localparam int R  = 4;
  localparam int C  = 5;
  localparam int SX = 128;
  localparam int SY = 64;
  localparam int AW = 8;
  localparam int W  = AW + 8;

  localparam int OR_N  = R + (C * SY) / 256;
  localparam int OC_N  = C + (R * SX) / 256;
  localparam int TOT   = OR_N * OC_N;
  localparam int BUDGET = 20000;

  logic          clk = 1'b0;
  logic          rst, start, s_valid, m_ready;
  logic          busy, done, s_ready, m_valid;
  logic [7:0]    s_data, m_data;
  logic [AW-1:0] m_addr;
  logic [2:0]    fsm_state;

  shear_stream_mapper #(
    .ROWS(R), .COLS(C), .SHEAR_X_Q8(SX), .SHEAR_Y_Q8(SY), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_data(m_data),
    .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  bit bp = 1'b0;

  logic [W-1:0]  exp_q[$];
  logic [7:0]    mem[0:255];
  logic [7:0]    pix[0:R-1][0:C-1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // downstream ready: random backpressure when bp is set
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_ready = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  // scoreboard / monitor, sampling on the falling edge
  initial begin
    logic          prev_stall;
    logic [AW-1:0] prev_addr;
    logic [7:0]    prev_data;
    logic [W-1:0]  e;
    prev_stall = 1'b0;
    prev_addr  = '0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall)
          check("stall_hold", {m_valid, m_addr, m_data}, {1'b1, prev_addr, prev_data});
        if (m_valid && m_ready) begin
          wr_cnt++;
          mem[m_addr] = m_data;
          if (exp_q.size() == 0) begin
            check("extra_write", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("txn", {m_addr, m_data}, e);
          end
        end
        if (done) begin
          done_cnt++;
          check("done_after_last", exp_q.size(), 0);
        end
        prev_stall = m_valid && !m_ready;
        prev_addr  = m_addr;
        prev_data  = m_data;
      end
    end
  end

  // reference model: whole-frame expected write sequence
  task automatic build_expected(input int mode, input bit with_map);
    int si, sj;
    exp_q.delete();
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        pix[r][c] = (mode == 0) ? 8'(10 * r + c) : 8'($urandom_range(0, 255));
    for (int a = 0; a < TOT; a++) exp_q.push_back({AW'(a), 8'd0});
    if (with_map)
      for (int r = 0; r < R; r++)
        for (int c = 0; c < C; c++) begin
          si = r + (c * SY) / 256;
          sj = c + (r * SX) / 256;
          if (si < OR_N && sj < OC_N) exp_q.push_back({AW'(si * OC_N + sj), pix[r][c]});
        end
  endtask

  task automatic drive_pixels(input int gap_pct, input bit poke_start);
    int  n;
    bit  ok;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) begin
        while ($urandom_range(0, 99) < gap_pct) begin
          s_valid = 1'b0;
          @(posedge clk);
          #1;
        end
        s_valid = 1'b1;
        s_data  = pix[r][c];
        if (poke_start && r == 2 && c == 0) start = 1'b1;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < BUDGET) begin
          @(negedge clk);
          ok = s_ready;
          @(posedge clk);
          #1;
          start = 1'b0;
          n++;
        end
        if (!ok) check("s_timeout", 1, 0);
      end
    s_valid = 1'b0;
  endtask

  task automatic run_frame(input int mode, input int gap_pct, input bit bp_on, input bit poke_start);
    int d0, n;
    bp = bp_on;
    build_expected(mode, 1'b1);
    wr_cnt = 0;
    d0 = done_cnt;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    drive_pixels(gap_pct, poke_start);
    n = 0;
    while (done_cnt == d0 && n < BUDGET) begin
      @(posedge clk);
      #2;
      n++;
    end
    repeat (3) @(posedge clk);
    #2;
    check("done_pulses", done_cnt - d0, 1);
    check("write_count", wr_cnt, TOT + R * C);
    check("exp_empty", exp_q.size(), 0);
    check("busy_low", busy, 0);
    check("idle_state", fsm_state, 0);
    check("m_valid_low", m_valid, 0);
    bp = 1'b0;
  endtask

  initial begin
    int d0;
    rst = 1'b1;
    start = 1'b0;
    s_valid = 1'b0;
    s_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_s_ready", s_ready, 0);
    check("rst_m_addr", m_addr, 0);
    check("rst_m_data", m_data, 0);
    check("rst_state", fsm_state, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_frame(0, 0, 1'b0, 1'b0);
    check("pix_0_0", mem[0], 0);
    check("pix_2_3", mem[18], 23);
    check("pix_3_4", mem[33], 34);

    run_frame(1, 0, 1'b1, 1'b0);
    run_frame(1, 30, 1'b0, 1'b0);
    run_frame(1, 20, 1'b1, 1'b1);

    // abort in the middle of the clear phase
    build_expected(1, 1'b0);
    d0 = done_cnt;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_m_valid", m_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_state", fsm_state, 0);
    check("abort_m_addr", m_addr, 0);
    exp_q.delete();
    repeat (4) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_stays_idle", {busy, m_valid}, 0);

    run_frame(1, 10, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
